// File: rtl/math_host_driver.sv
// math_host_driver
//   Initiator for the math accumulator op/data bus. Each accepted word-level
//   command (LOAD_A0, LOAD_A1, ADD, READ_A0) is expanded into a run of
//   registered {op_out, data_out} byte pairs, one pair per clock. READ_A0
//   collects the core's result one byte at a time into a BITS-wide response.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/ready/op/data  host command channel (op: 0=LOAD_A0 1=LOAD_A1
//                          2=ADD 3=READ_A0; data is the LOAD operand)
//   rsp_valid/ready/data   read result channel toward the host
//   op_out, data_out       opcode / data byte to the math core (NOP = 8'h00)
//   data_in                low byte of the core's selected accumulator
module math_host_driver #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [BITS-1:0] cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITS-1:0] rsp_data,
    output logic [7:0]      op_out,
    output logic [7:0]      data_out,
    input  logic [7:0]      data_in
);

    localparam int NB = BITS / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    // Core opcodes; the core selector bit is always 0 except for COPY (09),
    // which targets accum1 on purpose: accum1 <= accum0 + accum1 (cleared).
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_CLR0  = 8'h02;
    localparam logic [7:0] OP_CLR1  = 8'h03;
    localparam logic [7:0] OP_INS   = 8'h04;
    localparam logic [7:0] OP_ADD0  = 8'h08;
    localparam logic [7:0] OP_ADD1  = 8'h09;
    localparam logic [7:0] OP_SHL   = 8'h0A;
    localparam logic [7:0] OP_RD    = 8'h0C;
    localparam logic [7:0] BYTE_SH  = 8'h08;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        INS   = 3'd3,
        CLR1  = 3'd4,
        COPY  = 3'd5,
        RD    = 3'd6,
        RSP   = 3'd7
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [7:0]      op_r, op_s;
    logic [7:0]      dout_r, dout_s;
    logic [BITS-1:0] opnd_r, opnd_s;
    logic            is_a1_r, is_a1_s;
    logic [BITS-1:0] rsp_data_r, rsp_data_s;
    logic            cmd_ready_r;
    logic            rsp_valid_r;
    logic [BITS-1:0] opnd_shift_s;

    // Operand byte selected by the load counter (MSB first).
    assign opnd_shift_s = opnd_r >> {cnt_r, 3'b000};

    // Next-state, next op byte and response byte capture.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        op_s       = OP_NOP;
        dout_s     = 8'h00;
        opnd_s     = opnd_r;
        is_a1_s    = is_a1_r;
        rsp_data_s = rsp_data_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'd0, 2'd1: begin
                            opnd_s  = cmd_data;
                            is_a1_s = cmd_op[0];
                            state_s = CLR;
                            op_s    = OP_CLR0;
                        end
                        2'd2: begin
                            // Single op cycle; the driver stays ready.
                            op_s = OP_ADD0;
                        end
                        2'd3: begin
                            state_s = RD;
                            cnt_s   = {CW{1'b0}};
                            op_s    = OP_RD;
                            dout_s  = BYTE_SH;
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            CLR: begin
                state_s = SHIFT;
                cnt_s   = CNT_LAST;
                op_s    = OP_SHL;
                dout_s  = BYTE_SH;
            end
            SHIFT: begin
                state_s = INS;
                op_s    = OP_INS;
                dout_s  = opnd_shift_s[7:0];
            end
            INS: begin
                if (cnt_r == {CW{1'b0}}) begin
                    if (is_a1_r) begin
                        state_s = CLR1;
                        op_s    = OP_CLR1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    state_s = SHIFT;
                    op_s    = OP_SHL;
                    dout_s  = BYTE_SH;
                end
            end
            CLR1: begin
                state_s = COPY;
                op_s    = OP_ADD1;
            end
            COPY: begin
                state_s = IDLE;
            end
            RD: begin
                // data_in shows the byte about to be shifted out by this RD op.
                for (int j = 0; j < NB; j++) begin
                    if (cnt_r == CW'(j)) begin
                        rsp_data_s[j*8 +: 8] = data_in;
                    end else begin
                        rsp_data_s[j*8 +: 8] = rsp_data_r[j*8 +: 8];
                    end
                end
                if (cnt_r == CNT_LAST) begin
                    state_s = RSP;
                end else begin
                    cnt_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    op_s   = OP_RD;
                    dout_s = BYTE_SH;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RSP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset aborts any sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            op_r        <= 8'h00;
            dout_r      <= 8'h00;
            opnd_r      <= {BITS{1'b0}};
            is_a1_r     <= 1'b0;
            rsp_data_r  <= {BITS{1'b0}};
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            op_r        <= op_s;
            dout_r      <= dout_s;
            opnd_r      <= opnd_s;
            is_a1_r     <= is_a1_s;
            rsp_data_r  <= rsp_data_s;
            cmd_ready_r <= (state_s == IDLE);
            rsp_valid_r <= (state_s == RSP);
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign op_out    = op_r;
    assign data_out  = dout_r;

endmodule

// File: tb/tb_math_host_driver.sv
module tb_math_host_driver;

    localparam int BITS = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = 2'd0;
    logic [BITS-1:0] cmd_data = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [BITS-1:0] rsp_data;
    logic [7:0]      op_out;
    logic [7:0]      data_out;
    logic [7:0]      data_in;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0]     op_q[$];
    logic [BITS-1:0] rsp_q[$];
    logic [BITS-1:0] sw_a0 = '0;
    logic [BITS-1:0] sw_a1 = '0;
    logic [BITS-1:0] m_a0 = '0;
    logic [BITS-1:0] m_a1 = '0;

    math_host_driver #(.BITS(BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .op_out(op_out), .data_out(data_out), .data_in(data_in)
    );

    always #5 clk = ~clk;

    // Behavioural math core (accumulators are not reset).
    assign data_in = m_a0[7:0];
    always @(posedge clk) begin
        case (op_out)
            8'h02: m_a0 <= '0;
            8'h03: m_a1 <= '0;
            8'h04: m_a0 <= {m_a0[BITS-1:8], data_out};
            8'h08: m_a0 <= m_a0 + m_a1;
            8'h09: m_a1 <= m_a0 + m_a1;
            8'h0A: m_a0 <= m_a0 << data_out;
            8'h0C: m_a0 <= m_a0 >> 8;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every non-NOP op byte must match the next golden entry.
    always @(negedge clk) begin
        if (rst_n && op_out != 8'h00) begin
            if (op_q.size() == 0) begin
                check("op_extra", {56'd0, op_out}, 64'd0);
            end else begin
                check("op_byte", {48'd0, op_out, data_out}, {48'd0, op_q.pop_front()});
            end
        end
    end

    // Golden op trace plus command-level accumulator model.
    task automatic push_cmd(input logic [1:0] op, input logic [BITS-1:0] d, output int len);
        len = 0;
        case (op)
            2'd0, 2'd1: begin
                op_q.push_back(16'h0200); len++;
                for (int i = BITS/8 - 1; i >= 0; i--) begin
                    op_q.push_back(16'h0A08);
                    op_q.push_back({8'h04, d[i*8 +: 8]});
                    len += 2;
                end
                sw_a0 = d;
                if (op == 2'd1) begin
                    op_q.push_back(16'h0300);
                    op_q.push_back(16'h0900);
                    len += 2;
                    sw_a1 = d;
                end
            end
            2'd2: begin
                op_q.push_back(16'h0800); len++;
                sw_a0 = sw_a0 + sw_a1;
            end
            default: begin
                for (int i = 0; i < BITS/8; i++) begin
                    op_q.push_back(16'h0C08); len++;
                end
                rsp_q.push_back(sw_a0);
                sw_a0 = '0;
            end
        endcase
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk); t++;
        end
        if (!cmd_ready) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic take_rsp();
        int t = 0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk); t++;
        end
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        if (rsp_q.size() != 0) check("rsp_data", rsp_data, rsp_q.pop_front());
        else check("rsp_extra", 64'd1, 64'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_drop", {63'd0, rsp_valid}, 64'd0);
    endtask

    // Issue one command, then time its op burst; hold keeps cmd_valid high while busy.
    task automatic do_cmd(input logic [1:0] op, input logic [BITS-1:0] d, input bit hold, input bit auto_rsp);
        int len, n;
        wait_ready();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        push_cmd(op, d, len);
        @(posedge clk); #1;
        if (hold) begin
            cmd_op = 2'd2; cmd_data = '1;
        end else begin
            cmd_valid = 1'b0;
        end
        n = 0;
        while (op_q.size() != 0 && n < 100) begin
            @(negedge clk); #1; n++;
            if (hold && n == 10) cmd_valid = 1'b0;
        end
        check("op_len", 64'(n), 64'(len));
        if (op == 2'd3 && auto_rsp) take_rsp();
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_op", {56'd0, op_out}, 64'd0);
        check("rst_data", {56'd0, data_out}, 64'd0);
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_rvalid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rdata", rsp_data, 64'd0);
        rst_n = 1'b1;

        // 1: load / read round trip
        do_cmd(2'd0, 64'h0123456789ABCDEF, 1'b0, 1'b0);
        do_cmd(2'd3, '0, 1'b0, 1'b1);

        // 2: 5 + 7
        do_cmd(2'd0, 64'd5, 1'b0, 1'b0);
        do_cmd(2'd1, 64'd7, 1'b0, 1'b0);
        do_cmd(2'd0, 64'd5, 1'b0, 1'b0);
        do_cmd(2'd2, '0, 1'b0, 1'b0);
        do_cmd(2'd3, '0, 1'b0, 1'b1);

        // 3: wrap-around
        do_cmd(2'd1, 64'd1, 1'b0, 1'b0);
        do_cmd(2'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
        do_cmd(2'd2, '0, 1'b0, 1'b0);
        do_cmd(2'd3, '0, 1'b0, 1'b1);

        // 4: response back-pressure
        do_cmd(2'd0, 64'hDEADBEEF00C0FFEE, 1'b0, 1'b0);
        do_cmd(2'd3, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_data", rsp_data, 64'hDEADBEEF00C0FFEE);
            check("bp_ready", {63'd0, cmd_ready}, 64'd0);
            check("bp_op", {56'd0, op_out}, 64'd0);
        end
        cmd_valid = 1'b0;
        take_rsp();

        // 5: cmd_valid held during a busy load
        do_cmd(2'd0, 64'h1122334455667788, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_noextra", 64'(op_q.size()), 64'd0);
        do_cmd(2'd3, '0, 1'b0, 1'b1);

        // 6: reset in the middle of a load
        wait_ready();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 64'h5555555555555555;
        push_cmd(2'd0, 64'h5555555555555555, n);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_op", {56'd0, op_out}, 64'd0);
        check("arst_ready", {63'd0, cmd_ready}, 64'd1);
        op_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(2'd0, 64'hAA, 1'b0, 1'b0);
        do_cmd(2'd3, '0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        check("rsp_left", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
